// File: rtl/fifo_access_ctrl.sv
// Register-access FIFO with two arbitrated writers (host, core) and a single read-response port.
// Define FIFO_ACCESS_CTRL_RR_EN for round-robin write arbitration; otherwise core has fixed priority.
module fifo_access_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_main_a0,
  input  logic                     rst_main_n,
  input  logic                     host_wr_valid,
  input  logic [WIDTH-1:0]         host_wr_data,
  output logic                     host_wr_ready,
  input  logic                     core_wr_valid,
  input  logic [WIDTH-1:0]         core_wr_data,
  output logic                     core_wr_ready,
  input  logic                     rd_req,
  output logic                     rd_req_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [1:0]               rd_resp,
  input  logic                     rd_ready,
  input  logic                     clear,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] ERR_DATA = WIDTH'(32'hDEAD_DEAD);

  typedef enum logic {IDLE, RESP} rd_state_t;

  rd_state_t         state_q, state_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count_q;
  logic              grant_host, grant_core;
  logic              push, pop, accept;
  logic [WIDTH-1:0]  push_data;

  assign count = count_q;
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

`ifdef FIFO_ACCESS_CTRL_RR_EN
  // Remembers which writer wins the next contention; moves only on a real push.
  logic prefer_core;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n)
      prefer_core <= 1'b0;
    else if (push)
      prefer_core <= grant_host;
  end

  assign grant_core = core_wr_valid & (~host_wr_valid | prefer_core);
`else
  assign grant_core = core_wr_valid;
`endif

  assign grant_host    = host_wr_valid & ~grant_core;
  assign host_wr_ready = grant_host & ~full & ~clear;
  assign core_wr_ready = grant_core & ~full & ~clear;
  assign push          = (host_wr_valid & host_wr_ready) | (core_wr_valid & core_wr_ready);
  assign push_data     = grant_core ? core_wr_data : host_wr_data;
  assign pop           = accept & ~empty & ~clear;

  always_ff @(posedge clk_main_a0) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Set has priority over clear so an overflow racing ovf_clr is never lost.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n)
      overflow <= 1'b0;
    else if (core_wr_valid && full)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    rd_req_ready = 1'b0;
    rd_valid     = 1'b0;
    case (state_q)
      IDLE: begin
        rd_req_ready = 1'b1;
        if (rd_req) begin
          accept  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rd_valid = 1'b1;
        if (rd_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response is captured once on acceptance and held for the whole RESP phase.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      rd_data <= '0;
      rd_resp <= 2'b00;
    end else if (accept) begin
      rd_data <= pop ? mem[rd_ptr] : ERR_DATA;
      rd_resp <= pop ? 2'b00 : 2'b10;
    end
  end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Scoreboard bench for fifo_access_ctrl: a queue-based reference model predicts every read response.
// Honours FIFO_ACCESS_CTRL_RR_EN the same way as the design when predicting arbitration.
module tb_fifo_access_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] DEAD = 32'hDEAD_DEAD;
  localparam int NONE = 0, HOST = 1, CORE = 2;

  logic              clk_main_a0 = 1'b0;
  logic              rst_main_n  = 1'b0;
  logic              host_wr_valid = 1'b0;
  logic [WIDTH-1:0]  host_wr_data  = '0;
  logic              host_wr_ready;
  logic              core_wr_valid = 1'b0;
  logic [WIDTH-1:0]  core_wr_data  = '0;
  logic              core_wr_ready;
  logic              rd_req = 1'b0;
  logic              rd_req_ready;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;
  logic [1:0]        rd_resp;
  logic              rd_ready = 1'b0;
  logic              clear    = 1'b0;
  logic              ovf_clr  = 1'b0;
  logic [CW-1:0]     count;
  logic              full, empty, overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO contents as a plain queue, a pending-response flag,
  // the sticky overflow bit and the identity of the last successful writer.
  logic [WIDTH-1:0]  model_q[$];
  logic [WIDTH+1:0]  sb_q[$];
  bit                m_busy;
  bit                m_ovf;
  int                last_pusher;

  fifo_access_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_main_a0   (clk_main_a0),
    .rst_main_n    (rst_main_n),
    .host_wr_valid (host_wr_valid),
    .host_wr_data  (host_wr_data),
    .host_wr_ready (host_wr_ready),
    .core_wr_valid (core_wr_valid),
    .core_wr_data  (core_wr_data),
    .core_wr_ready (core_wr_ready),
    .rd_req        (rd_req),
    .rd_req_ready  (rd_req_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_resp       (rd_resp),
    .rd_ready      (rd_ready),
    .clear         (clear),
    .ovf_clr       (ovf_clr),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkState();
    checkOutput("count", 64'(count), 64'(model_q.size()));
    checkOutput("empty", 64'(empty), 64'(model_q.size() == 0));
    checkOutput("full", 64'(full), 64'(model_q.size() == DEPTH));
    checkOutput("overflow", 64'(overflow), 64'(m_ovf));
    checkOutput("rd_valid", 64'(rd_valid), 64'(m_busy));
    checkOutput("rd_req_ready", 64'(rd_req_ready), 64'(!m_busy));
  endtask

  // One clock cycle: check registered state, drive inputs, check readies, advance the model.
  task automatic applyStimulus(input bit hv, input logic [WIDTH-1:0] hd,
                               input bit cv, input logic [WIDTH-1:0] cd,
                               input bit rq, input bit rr, input bit clr, input bit oc,
                               output bit h_acc, output bit c_acc);
    bit m_full, g_core, g_host;
    @(posedge clk_main_a0);
    #1;
    checkState();
    host_wr_valid = hv;  host_wr_data = hd;
    core_wr_valid = cv;  core_wr_data = cd;
    rd_req = rq;  rd_ready = rr;  clear = clr;  ovf_clr = oc;
    #1;
    m_full = (model_q.size() == DEPTH);
    if (hv && cv) begin
`ifdef FIFO_ACCESS_CTRL_RR_EN
      g_core = (last_pusher == HOST);
`else
      g_core = 1'b1;
`endif
    end else begin
      g_core = cv;
    end
    g_host = hv && !g_core;
    h_acc  = g_host && !m_full && !clr;
    c_acc  = g_core && !m_full && !clr;
    checkOutput("host_wr_ready", 64'(host_wr_ready), 64'(h_acc));
    checkOutput("core_wr_ready", 64'(core_wr_ready), 64'(c_acc));
    if (cv && m_full)
      m_ovf = 1'b1;
    else if (oc)
      m_ovf = 1'b0;
    if (!m_busy) begin
      if (rq) begin
        if (model_q.size() > 0 && !clr)
          sb_q.push_back({2'b00, model_q.pop_front()});
        else
          sb_q.push_back({2'b10, DEAD});
        m_busy = 1'b1;
      end
    end else if (rr) begin
      m_busy = 1'b0;
    end
    if (clr) begin
      model_q.delete();
    end else if (h_acc || c_acc) begin
      model_q.push_back(c_acc ? cd : hd);
      last_pusher = c_acc ? CORE : HOST;
    end
  endtask

  task automatic doReset();
    @(posedge clk_main_a0);
    #1;
    rst_main_n = 1'b0;
    host_wr_valid = 1'b0; core_wr_valid = 1'b0; rd_req = 1'b0;
    rd_ready = 1'b0; clear = 1'b0; ovf_clr = 1'b0;
    #1;
    model_q.delete();
    sb_q.delete();
    m_busy = 1'b0;
    m_ovf = 1'b0;
    last_pusher = NONE;
    checkState();
    checkOutput("rst_rd_data", 64'(rd_data), 64'd0);
    checkOutput("rst_rd_resp", 64'(rd_resp), 64'd0);
    @(posedge clk_main_a0);
    #1;
    rst_main_n = 1'b1;
  endtask

  // Monitor: every completed read handshake is matched against the oldest prediction.
  always @(negedge clk_main_a0) begin
    if (rst_main_n && rd_valid && rd_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rd_unexpected actual=0x%0h required=no response at %0t", rd_data, $time);
      end else begin
        logic [WIDTH+1:0] exp;
        exp = sb_q.pop_front();
        checkOutput("rd_data", 64'(rd_data), 64'(exp[WIDTH-1:0]));
        checkOutput("rd_resp", 64'(rd_resp), 64'(exp[WIDTH+1:WIDTH]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ha, ca;
    int hi, ci;
    int rd_pct;
    doReset();

    // Two host pushes read back in order.
    applyStimulus(1, 32'h11, 0, 0, 0, 1, 0, 0, ha, ca);
    applyStimulus(1, 32'h22, 0, 0, 0, 1, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, ha, ca);

    // Read of an empty FIFO returns the error word.
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, ha, ca);

    // Fill, stall both writers, raise and clear overflow.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 32'h100 + i, 0, 0, 0, 1, 0, 0, ha, ca);
    applyStimulus(1, 32'hAAAA, 1, 32'hBBBB, 0, 1, 0, 0, ha, ca);
    applyStimulus(1, 32'hAAAA, 0, 0, 0, 1, 0, 0, ha, ca);
    applyStimulus(0, 0, 1, 32'hBBBB, 0, 1, 0, 1, ha, ca);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, ha, ca);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, ha, ca);

    // Contention between writers with proper valid/ready data advance.
    doReset();
    hi = 0; ci = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'hA0 + hi, 1, 32'hC0 + ci, 0, 1, 0, 0, ha, ca);
      if (ha) hi++;
      if (ca) ci++;
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, ha, ca);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, ha, ca);
    end

    // Push and pop together at count 1 returns the old head.
    applyStimulus(1, 32'h44, 0, 0, 0, 1, 0, 0, ha, ca);
    applyStimulus(1, 32'h33, 0, 0, 1, 1, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, ha, ca);

    // Clear with a push while a response is still pending.
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 32'h200 + i, 0, 0, 0, 0, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, ha, ca);
    applyStimulus(1, 32'h2FF, 0, 0, 0, 0, 1, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, ha, ca);

    // Reset in the middle of a pending response.
    applyStimulus(1, 32'h55, 0, 0, 0, 0, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, ha, ca);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, ha, ca);
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, ha, ca);

    // Randomised traffic with phases biased toward filling and draining.
    for (int phase = 0; phase < 6; phase++) begin
      rd_pct = (phase % 2 == 0) ? 15 : 70;
      for (int i = 0; i < 500; i++) begin
        applyStimulus($urandom_range(0, 1) == 1, $urandom,
                      $urandom_range(0, 1) == 1, $urandom,
                      $urandom_range(0, 99) < rd_pct,
                      $urandom_range(0, 2) != 0,
                      $urandom_range(0, 59) == 0,
                      $urandom_range(0, 9) == 0,
                      ha, ca);
      end
    end

    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, ha, ca);
    @(posedge clk_main_a0);
    #1;
    checkOutput("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_access_ctrl.md
FIFO_ACCESS_CTRL -- requirements
Module: fifo_access_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; must be a power of 2, at least 2.
REQ-003 SHALL have port clk_main_a0, input, 1 bit: clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_main_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port host_wr_valid/host_wr_data/host_wr_ready (in 1 / in WIDTH / out 1): host-register push request.
REQ-006 SHALL have port core_wr_valid/core_wr_data/core_wr_ready (in 1 / in WIDTH / out 1): core-result push request.
REQ-007 SHALL have port rd_req/rd_req_ready (in 1 / out 1): read request from the register decode.
REQ-008 SHALL have port rd_valid/rd_data/rd_resp/rd_ready (out 1 / out WIDTH / out 2 / in 1): read response.
REQ-009 SHALL have port clear, input, 1 bit: synchronous flush.
REQ-010 SHALL have port ovf_clr, input, 1 bit: clears overflow.
REQ-011 SHALL have port count, output, log2(DEPTH)+1 bits: occupancy.
REQ-012 SHALL have ports full, empty, overflow, each output, 1 bit.

Function
REQ-013 SHALL store up to DEPTH entries in internal storage with wrapping read/write pointers; count = writes - reads; full = (count==DEPTH); empty = (count==0).
REQ-014 SHALL grant at most one writer per cycle; push occurs on valid&ready of the granted writer.
REQ-015 SHALL drive each x_wr_ready as: grant to x AND !full AND !clear; a non-granted writer's ready is 0.
REQ-016 SHALL grant a lone valid writer immediately; when both are valid, grant per REQ-030/031.
REQ-017 SHALL implement a read FSM with two states: IDLE, where rd_req_ready=1 and rd_valid=0; and RESP, where rd_req_ready=0, rd_valid=1, and rd_data/rd_resp are held stable.
REQ-018 SHALL, on rd_req in IDLE when not empty and not clear, pop the head entry, load it into rd_data, set rd_resp=2'b00, and go to RESP the next cycle, so rd_req in cycle N gives rd_valid in N+1.
REQ-019 SHALL, on rd_req in IDLE when empty or clear, pop nothing, set rd_data=32'hDEAD_DEAD (zero-extended/truncated to WIDTH), set rd_resp=2'b10, and go to RESP.
REQ-020 SHALL leave RESP for IDLE on rd_ready; rd_req seen during RESP is ignored.
REQ-021 SHALL, on a simultaneous push and pop, leave count unchanged; a pop when count==1 with a simultaneous push returns the old head.
REQ-022 SHALL make pushed data poppable from the cycle after the push; empty/count update one cycle after the push/pop edge.
REQ-023 SHALL set overflow (sticky) on core_wr_valid while full; ovf_clr clears it; a simultaneous set and clear leaves it set.
REQ-024 SHALL, on clear, reset pointers/count to 0 next cycle; clear beats push/pop in the same cycle; an in-flight RESP completes unchanged.
REQ-025 SHALL leave the host writer never able to set overflow; it simply stalls.

Reset
REQ-026 SHALL, during reset, hold pointers/count=0, empty=1, full=0, overflow=0, FSM=IDLE, rd_valid=0, rd_data=0, rd_resp=0, and writer grant pointer=host.
REQ-027 SHALL make reset assertion take effect immediately (async) and deassertion synchronous to clk_main_a0; reset mid-read drops RESP with no pop replay.
REQ-028 SHALL leave storage contents unreset; they are don't-care.

Configuration
REQ-029 SHALL compile round-robin arbitration when macro FIFO_ACCESS_CTRL_RR_EN is defined.
REQ-030 SHALL, with FIFO_ACCESS_CTRL_RR_EN defined, resolve a contention by granting the writer not granted in the last successful push; the pointer updates only on an actual push; first contention after reset goes to host.
REQ-031 SHALL, without FIFO_ACCESS_CTRL_RR_EN, always give core priority over host under contention.

Verification
REQ-032 SHALL cover: after reset, push host 0x11, 0x22, then rd_req x2 with rd_ready=1 -> rd_data 0x11 then 0x22, rd_resp 0, count 0, empty=1.
REQ-033 SHALL cover: rd_req on empty FIFO -> rd_valid next cycle, rd_data 0xDEAD_DEAD, rd_resp 2'b10, count stays 0.
REQ-034 SHALL cover: push 16 entries -> full=1, both readies 0; core_wr_valid -> overflow=1; ovf_clr -> overflow=0.
REQ-035 SHALL cover, with RR_EN: both valid for 4 cycles with data H0..H3 and C0..C3 -> pop order H0,C0,H1,C1; without RR_EN -> C0,C1,C2,C3.
REQ-036 SHALL cover: count=1, push 0x33 with a concurrent rd_req -> rd_data=old head, count stays 1, next read 0x33.
REQ-037 SHALL cover: count=5, clear together with host push -> next cycle count 0, empty=1, push dropped; a pending RESP still completes.
